// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and constants for the CV32E40P OBI instruction/data arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cv32e40p_obi_pkg;

  // Identifies which master port issued an outstanding transaction.
  typedef enum logic {
    OBI_SRC_INSTR = 1'b0,
    OBI_SRC_DATA  = 1'b1
  } obi_src_e;

  // Instruction fetches always read a full word.
  localparam logic [3:0] OBI_INSTR_BE = 4'hF;

endpackage

// File: rtl/cv32e40p_obi_src_fifo.sv
// In-order FIFO of source ids; one entry per accepted-but-unanswered transaction.
// Latency: push is visible at the head on the next cycle; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; the caller gates on full_o/empty_o.
module cv32e40p_obi_src_fifo
  import cv32e40p_obi_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  obi_src_e                     src_i,
  input  logic                         pop_i,
  output obi_src_e                     head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  obi_src_e        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= OBI_SRC_INSTR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= src_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/cv32e40p_obi_arbiter.sv
// Two-to-one OBI arbiter merging instruction and data masters onto one slave port.
// Latency: zero-cycle address phase and zero-cycle response routing (both combinational).
// Backpressure: ungranted requests are locked until accepted; no request is issued while the source FIFO is full.
module cv32e40p_obi_arbiter
  import cv32e40p_obi_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          DATA_FIRST      = 1'b1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   instr_req_i,
  output logic                                   instr_gnt_o,
  input  logic [31:0]                            instr_addr_i,
  output logic                                   instr_rvalid_o,
  output logic [31:0]                            instr_rdata_o,
  input  logic                                   data_req_i,
  output logic                                   data_gnt_o,
  input  logic                                   data_we_i,
  input  logic [3:0]                             data_be_i,
  input  logic [31:0]                            data_addr_i,
  input  logic [31:0]                            data_wdata_i,
  output logic                                   data_rvalid_o,
  output logic [31:0]                            data_rdata_o,
  output logic                                   mem_req_o,
  input  logic                                   mem_gnt_i,
  output logic                                   mem_we_o,
  output logic [3:0]                             mem_be_o,
  output logic [31:0]                            mem_addr_o,
  output logic [31:0]                            mem_wdata_o,
  input  logic                                   mem_rvalid_i,
  input  logic [31:0]                            mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam obi_src_e RR_INIT = DATA_FIRST ? OBI_SRC_DATA : OBI_SRC_INSTR;

  obi_src_e sel;
  obi_src_e rr_q;
  obi_src_e lock_src_q;
  obi_src_e head_src;
  logic     lock_q;
  logic     sel_req;
  logic     accept;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;

  // Source selection: a locked source wins, otherwise the lone requester, otherwise round-robin.
  always_comb begin
    sel = rr_q;
    if (lock_q)                         sel = lock_src_q;
    else if (instr_req_i && !data_req_i) sel = OBI_SRC_INSTR;
    else if (data_req_i && !instr_req_i) sel = OBI_SRC_DATA;
  end

  assign sel_req   = (sel == OBI_SRC_DATA) ? data_req_i : instr_req_i;
  // Full blocks issue even when a pop lands this cycle, so mem_req_o never depends on mem_rvalid_i.
  assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full;
  assign accept    = mem_req_o & mem_gnt_i;

  // Address-phase mux; instruction fetches are full-word reads.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = OBI_INSTR_BE;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (sel == OBI_SRC_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign instr_gnt_o = accept & (sel == OBI_SRC_INSTR);
  assign data_gnt_o  = accept & (sel == OBI_SRC_DATA);

  // Lock holds an ungranted selection stable; a master that abandons its request releases it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= OBI_SRC_INSTR;
    end else if (lock_q && !sel_req) begin
      lock_q <= 1'b0;
    end else if (mem_req_o && !mem_gnt_i) begin
      lock_q     <= 1'b1;
      lock_src_q <= sel;
    end else if (accept) begin
      lock_q <= 1'b0;
    end
  end

  // Round-robin pointer moves to the source that was not granted, only on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     rr_q <= RR_INIT;
    else if (accept) rr_q <= (sel == OBI_SRC_DATA) ? OBI_SRC_INSTR : OBI_SRC_DATA;
  end

  assign pop = mem_rvalid_i & ~fifo_empty;

  cv32e40p_obi_src_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_src_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .src_i   (sel),
    .pop_i   (pop),
    .head_o  (head_src),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  // Responses go to whichever port issued the oldest outstanding transaction.
  assign instr_rvalid_o = pop & (head_src == OBI_SRC_INSTR);
  assign data_rvalid_o  = pop & (head_src == OBI_SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  // Protocol monitors: response with nothing outstanding, and a master dropping a locked request.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(mem_rvalid_i && fifo_empty))
        else $warning("obi arbiter: rvalid with no outstanding transaction, dropped");
      assert (!(lock_q && !sel_req))
        else $warning("obi arbiter: master dropped req while locked and ungranted");
    end
  end

endmodule
